int_ctrl: RTL
=============

Name: int_ctrl

Overview:
- 8-source vectored interrupt controller feeding the single-cycle CPU control unit.
- Synchronises and edge-detects peripheral requests, latches them as pending, and applies an enable mask.
- Presents the highest-priority eligible request to the control unit as a one-hot `min_bit_s`, and the highest-priority in-service source as a one-hot `min_bit_a`.
- Consumes the control unit's `s_calli` (acknowledge) and `s_reti` (return) one-hot strobes to move sources between pending and in-service.

Parameters:
- N, 8, number of sources; fixed at 8 to match the 8-bit `s_calli`/`s_reti`/`min_bit_*` buses.
- SYNC_STAGES, 2, flip-flop stages on each `irq` input; legal values 2 or 3.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq  in  8  raw peripheral requests; asynchronous level inputs; a rising edge requests service.
- ien_we  in  1  enable-register write strobe.
- ien_in  in  8  enable-register write data; 1 enables the source.
- pclr_we  in  1  pending/lost clear strobe.
- pclr_in  in  8  bits to clear in `pend` and `lost`.
- s_calli  in  8  acknowledge from the CU; one-hot or 0.
- s_reti  in  8  return from the CU; one-hot or 0.
- min_bit_s  out  8  one-hot request to the CU, or 0.
- min_bit_a  out  8  one-hot lowest-index set bit of `isr`, or 0.
- pend_o  out  8  pending register.
- isr_o  out  8  in-service register.
- lost_o  out  8  sticky lost-edge flags.

Behaviour:
- Priority: bit 0 is highest, bit 7 lowest. This matches the CU's numeric comparison `min_bit_s < min_bit_a`.
- Reset (async, immediate): clears every register. Sync chain, edge history, `pend`, `isr`, `ien` and `lost` all go to 0, so every output is 0 while reset is high. Deassertion takes effect at the next clock edge.
- Synchroniser: `irq[i]` passes through SYNC_STAGES flops to give `s[i]`; `prev[i]` is `s[i]` delayed one clock.
- Edge detect: `edge[i] = s[i] & ~prev[i]`.
- Latency: with SYNC_STAGES=2, an `irq` rise ahead of edge k sets `pend` at edge k+2, and `min_bit_s` is valid combinationally after edge k+2.
- Pending update: `pend_next = (pend & ~s_calli & ~(pclr_we ? pclr_in : 0)) | edge`.
  - A new edge wins over a same-cycle acknowledge or clear.
- Lost flag:
  - Set: `lost[i]` sets when `edge[i]` arrives while `pend[i]` is already 1 and is not being acknowledged that cycle.
  - Clear: only by `pclr_we` with `pclr_in[i]=1`.
  - Conflict: set wins over a same-cycle clear.
- In-service update: `isr_next = (isr & ~s_reti) | s_calli`.
  - A return and an acknowledge in the same cycle both apply.
  - The same bit in both sets it.
  - `s_calli` bits are honoured even if not pending. The CU injects `8'b00000001` for ALU overflow, which makes source 0 in service.
- Enable register: `ien` loads `ien_in` when `ien_we` is high.
  - Disabled sources still latch into `pend` and surface once enabled.
- `min_bit_s` (combinational from registers only, no combinational path from any input port):
  - `elig = pend & ien`.
  - `cand` = lowest-index set bit of `elig`.
  - Output `cand` only if `isr == 0` or `cand < min_bit_a` (strictly higher priority); otherwise 0.
  - Equal-priority re-entry is never presented.
- `min_bit_a`: lowest-index set bit of `isr`. This is the active level; lower-priority nested entries stay in `isr` underneath it.
- Non-one-hot `s_calli`/`s_reti`: applied bitwise without checking; driving them is a CU error.
- Reset mid-service: all nesting state is lost; no `min_bit_s` until new edges arrive after reset release.
- Level held high: produces a single edge, so one pending entry only. A new request needs a low-then-high on `irq`.

Test Plan:
- Basic request:
  - Stimulus: reset, `ien=8'hFF`, pulse `irq[3]` high.
  - Response: `pend_o=8'h08` and `min_bit_s=8'h08` two clocks after the sync rise.
  - Then `s_calli=8'h08` for one cycle: `pend_o=0`, `isr_o=8'h08`, `min_bit_a=8'h08`, `min_bit_s=0`.
- Priority and nesting:
  - Stimulus: `isr=8'h08`, raise `irq[5]` then `irq[1]`.
  - Response: `min_bit_s=8'h02` (never `8'h20`).
  - Ack `8'h02`: `isr_o=8'h0A`, `min_bit_a=8'h02`.
  - `s_reti=8'h02`: `min_bit_a=8'h08`.
  - `s_reti=8'h08`: `min_bit_s=8'h20`.
- Mask:
  - Stimulus: `ien=8'h00`, edge on `irq[2]`.
  - Response: `pend_o=8'h04`, `min_bit_s=0`.
  - Write `ien=8'h04`: next cycle `min_bit_s=8'h04`.
- Lost edge and clear:
  - Stimulus: two edges on `irq[6]` without ack.
  - Response: `lost_o=8'h40`.
  - `pclr_we`, `pclr_in=8'h40`: `pend_o=0`, `lost_o=0`.
  - Same-cycle new edge plus clear: `pend_o[6]=1`.
- Overflow injection:
  - Stimulus: `s_calli=8'h01` with `pend=0`, `isr=8'h10`.
  - Response: `isr_o=8'h11`, `min_bit_a=8'h01`.
  - Simultaneous `s_reti=8'h01` and `s_calli=8'h04`: `isr_o=8'h14`.
- Async reset mid-service:
  - Stimulus: assert reset between clock edges with `isr=8'h0C` and `pend=8'h80`.
  - Response: all outputs 0 immediately, held until the first new edge after release.

Source files
------------

// File: rtl/int_ctrl.sv
// 8-source vectored interrupt controller: synchronise and edge-detect requests, track pending,
// in-service and lost state, and present the highest-priority eligible request to the CU.
module int_ctrl #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq,
  input  logic         ien_we,
  input  logic [N-1:0] ien_in,
  input  logic         pclr_we,
  input  logic [N-1:0] pclr_in,
  input  logic [N-1:0] s_calli,
  input  logic [N-1:0] s_reti,
  output logic [N-1:0] min_bit_s,
  output logic [N-1:0] min_bit_a,
  output logic [N-1:0] pend_o,
  output logic [N-1:0] isr_o,
  output logic [N-1:0] lost_o
);

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0] prev_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] isr_q;
  logic [N-1:0] ien_q;
  logic [N-1:0] lost_q;

  logic [N-1:0] s;
  logic [N-1:0] rise;
  logic [N-1:0] clr_mask;
  logic [N-1:0] elig;
  logic [N-1:0] cand;
  logic [N-1:0] act;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~prev_q;
  assign clr_mask = pclr_we ? pclr_in : '0;

  // A new edge beats a same-cycle ack or clear; a lost-set beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      ien_q  <= '0;
      lost_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      prev_q <= s;
      pend_q <= (pend_q & ~s_calli & ~clr_mask) | rise;
      lost_q <= (lost_q & ~clr_mask) | (rise & pend_q & ~s_calli);
      isr_q  <= (isr_q & ~s_reti) | s_calli;
      if (ien_we) begin
        ien_q <= ien_in;
      end
    end
  end

  // Lowest set bit isolates the highest priority; a request is shown only if it outranks the active level.
  always_comb begin
    elig      = pend_q & ien_q;
    cand      = elig & (~elig + N'(1));
    act       = isr_q & (~isr_q + N'(1));
    min_bit_a = act;
    min_bit_s = '0;
    if ((cand != '0) && ((isr_q == '0) || (cand < act))) begin
      min_bit_s = cand;
    end
  end

  assign pend_o = pend_q;
  assign isr_o  = isr_q;
  assign lost_o = lost_q;

endmodule
